sdram_port_arbiter: RTL and testbench



---
 rtl/sdram_arb_pkg.sv | 17 +
 rtl/sdram_port_arbiter_if.sv | 59 +++++
 rtl/sdram_port_arbiter_rr.sv | 36 +++
 rtl/sdram_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM controller arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACCEPT,
    ST_WAIT_DONE
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int unsigned DEF_ADDR_W = 25;
  localparam int unsigned DEF_DATA_W = 16;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Requester ports and controller-side bus of the SDRAM port arbiter.
interface sdram_port_arbiter_if
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_done;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_err;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_done;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_err;

  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_enable;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_enable;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ready;
  logic              busy;

  logic              arb_busy;
  logic              arb_owner;

  // Arbiter's view.
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  rd_data, rd_ready, busy,
    output p0_done, p0_rdata, p0_err,
    output p1_done, p1_rdata, p1_err,
    output wr_addr, wr_data, wr_enable, rd_addr, rd_enable,
    output arb_busy, arb_owner
  );

  // Requesters' and controller's view.
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output rd_data, rd_ready, busy,
    input  p0_done, p0_rdata, p0_err,
    input  p1_done, p1_rdata, p1_err,
    input  wr_addr, wr_data, wr_enable, rd_addr, rd_enable,
    input  arb_busy, arb_owner
  );

endinterface

// File: rtl/sdram_port_arbiter_rr.sv
// Two-way round-robin picker; remembers the last granted port.
module rr_arbiter2
  import sdram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       grant_valid,
  output logic       grant_idx,
  output logic       owner
);

  logic owner_q, owner_d;

  always_comb begin
    grant_idx = owner_q;
    case (req)
      2'b01:   grant_idx = PORT_CPU;
      2'b10:   grant_idx = PORT_DBG;
      2'b11:   grant_idx = ~owner_q;
      default: grant_idx = owner_q;
    endcase
    grant_valid = grant_en && (|req);
    owner_d     = grant_valid ? grant_idx : owner_q;
  end

  // Reset to DBG so that CPU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) owner_q <= PORT_DBG;
    else        owner_q <= owner_d;
  end

  assign owner = owner_q;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Serialises CPU and debugger/DMA transactions onto one SDRAM controller port.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input logic               clk,
  input logic               rst_n,
  sdram_port_arbiter_if.slave bus
);

  localparam int unsigned        TMR_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0]   TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);

  arb_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d, tmr_next;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              grant_en, grant_valid, grant_idx, owner;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              finish, abort;

  // No grant while a done pulse is out: the requester still holds req that cycle.
  assign grant_en = (state_q == ST_IDLE) && !bus.busy && !(|done_q);

  rr_arbiter2 u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        ({bus.p1_req, bus.p0_req}),
    .grant_en   (grant_en),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx),
    .owner      (owner)
  );

  assign sel_we    = (grant_idx == PORT_DBG) ? bus.p1_we    : bus.p0_we;
  assign sel_addr  = (grant_idx == PORT_DBG) ? bus.p1_addr  : bus.p0_addr;
  assign sel_wdata = (grant_idx == PORT_DBG) ? bus.p1_wdata : bus.p0_wdata;

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    tmr_d     = tmr_q;
    done_d    = '0;
    err_d     = '0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    tmr_next  = tmr_q + TMR_W'(1);
    finish    = 1'b0;
    abort     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          we_d = sel_we;
          if (sel_we) begin
            wr_addr_d = sel_addr;
            wr_data_d = sel_wdata;
            wr_en_d   = 1'b1;
          end else begin
            rd_addr_d = sel_addr;
            rd_en_d   = 1'b1;
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmr_d   = '0;
        state_d = ST_WAIT_ACCEPT;
      end
      ST_WAIT_ACCEPT: begin
        tmr_d = tmr_next;
        if (!we_q && bus.rd_ready)    finish  = 1'b1;
        else if (tmr_next == TMR_LIMIT) abort = 1'b1;
        else if (bus.busy)            state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        tmr_d = tmr_next;
        if (we_q ? !bus.busy : bus.rd_ready) finish = 1'b1;
        else if (tmr_next == TMR_LIMIT)      abort  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (finish || abort) begin
      state_d       = ST_IDLE;
      done_d[owner] = 1'b1;
      err_d[owner]  = abort;
    end

    if (finish && !we_q) begin
      if (owner == PORT_DBG) rdata1_d = bus.rd_data;
      else                   rdata0_d = bus.rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      tmr_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      tmr_q     <= tmr_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_enable = wr_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.rd_enable = rd_en_q;
  assign bus.p0_done   = done_q[PORT_CPU];
  assign bus.p0_err    = err_q[PORT_CPU];
  assign bus.p0_rdata  = rdata0_q;
  assign bus.p1_done   = done_q[PORT_DBG];
  assign bus.p1_err    = err_q[PORT_DBG];
  assign bus.p1_rdata  = rdata1_q;
  assign bus.arb_busy  = (state_q != ST_IDLE);
  assign bus.arb_owner = owner;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomised bench for sdram_port_arbiter against a transaction-level schedule model.
module tb_sdram_port_arbiter;
  import sdram_arb_pkg::*;

  localparam int unsigned AW = 25;
  localparam int unsigned DW = 16;
  localparam int          TO = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Current transaction: granted at g_cyc, completion sampled at c_cyc, done at c_cyc+1.
  bit          inflight;
  int          g_cyc, c_cyc, kind, a, b, own, last_owner;
  logic          t_we;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata, t_rdata;
  logic [DW-1:0] exp_rdata [2];

  logic          m_req [2];
  logic          m_we  [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdata [2];

  bit          auto_req, f_en;
  int          f_kind, f_a, f_b, busy_until, dc;
  logic [DW-1:0] f_data;
  int          done_cnt [2];
  int          err_cnt [2];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int p, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd);
    m_req[p]   = 1'b1;
    m_we[p]    = we;
    m_addr[p]  = addr;
    m_wdata[p] = wd;
  endtask

  task automatic rand_req(input int p);
    set_req(p, 1'($urandom), AW'($urandom), DW'($urandom));
  endtask

  task automatic drive_inputs(input logic busy_v, input logic rdy_v, input logic [DW-1:0] rd_v);
    bus.busy     = busy_v;
    bus.rd_ready = rdy_v;
    bus.rd_data  = rd_v;
    bus.p0_req   = m_req[0];
    bus.p0_we    = m_we[0];
    bus.p0_addr  = m_addr[0];
    bus.p0_wdata = m_wdata[0];
    bus.p1_req   = m_req[1];
    bus.p1_we    = m_we[1];
    bus.p1_addr  = m_addr[1];
    bus.p1_wdata = m_wdata[1];
  endtask

  // One clock: observe cycle outputs at negedge, then drive this cycle's inputs.
  task automatic step();
    bit done_now, issue_now, busy_v, rdy_v;
    int w0, r;
    @(negedge clk);
    cyc++;
    done_now  = inflight && (cyc == c_cyc + 1);
    issue_now = inflight && (cyc == g_cyc + 1);
    if (done_now && !t_we && kind != 2) exp_rdata[own] = t_rdata;

    chk("wr_enable", bus.wr_enable, issue_now && t_we);
    chk("rd_enable", bus.rd_enable, issue_now && !t_we);
    if (issue_now) begin
      if (t_we) begin
        chk("wr_addr", bus.wr_addr, t_addr);
        chk("wr_data", bus.wr_data, t_wdata);
      end else begin
        chk("rd_addr", bus.rd_addr, t_addr);
      end
    end
    chk("p0_done", bus.p0_done, done_now && own == 0);
    chk("p1_done", bus.p1_done, done_now && own == 1);
    chk("p0_err", bus.p0_err, done_now && own == 0 && kind == 2);
    chk("p1_err", bus.p1_err, done_now && own == 1 && kind == 2);
    chk("p0_rdata", bus.p0_rdata, exp_rdata[0]);
    chk("p1_rdata", bus.p1_rdata, exp_rdata[1]);
    chk("arb_busy", bus.arb_busy, inflight && cyc > g_cyc && cyc <= c_cyc);
    chk("arb_owner", bus.arb_owner, last_owner);
    if (bus.p0_done) done_cnt[0]++;
    if (bus.p1_done) done_cnt[1]++;
    if (bus.p0_err)  err_cnt[0]++;
    if (bus.p1_err)  err_cnt[1]++;

    if (done_now) begin
      inflight = 1'b0;
      m_req[own] = 1'b0;
      if (auto_req && $urandom_range(1, 0) == 1) rand_req(own);
    end

    // Controller response script, relative to the first wait cycle w0.
    busy_v = 1'b0;
    rdy_v  = 1'b0;
    w0     = g_cyc + 2;
    if (inflight && cyc >= w0) begin
      if (kind == 0) begin
        busy_v = (cyc >= w0 + a) && (cyc < w0 + a + b);
        rdy_v  = !t_we && (cyc == w0 + a + b);
      end else if (kind == 1) begin
        rdy_v = (cyc == w0 + a);
      end
    end else if (!inflight) begin
      busy_v = (cyc < busy_until) || (auto_req && $urandom_range(5, 0) == 0);
    end

    if (auto_req)
      for (int p = 0; p < 2; p++)
        if (!m_req[p] && $urandom_range(3, 0) == 0) rand_req(p);

    if (!inflight && !done_now && !busy_v && (m_req[0] || m_req[1])) begin
      own        = (m_req[0] && m_req[1]) ? 1 - last_owner : (m_req[0] ? 0 : 1);
      last_owner = own;
      inflight   = 1'b1;
      g_cyc      = cyc;
      t_we       = m_we[own];
      t_addr     = m_addr[own];
      t_wdata    = m_wdata[own];
      t_rdata    = DW'($urandom);
      if (f_en) begin
        kind = f_kind; a = f_a; b = f_b; t_rdata = f_data; f_en = 1'b0;
      end else begin
        r    = $urandom_range(99, 0);
        kind = (r < 8) ? 2 : ((!t_we && r < 35) ? 1 : 0);
        a    = $urandom_range(3, 0);
        b    = $urandom_range(5, 1);
      end
      c_cyc = (kind == 2) ? g_cyc + 1 + TO : ((kind == 1) ? g_cyc + 2 + a : g_cyc + 2 + a + b);
    end

    drive_inputs(busy_v, rdy_v, rdy_v ? t_rdata : DW'($urandom));
  endtask

  // Asserts reset off the clock edge, checks outputs asynchronously, releases at a negedge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    inflight = 1'b0; last_owner = 1; f_en = 1'b0; busy_until = 0;
    for (int p = 0; p < 2; p++) begin
      m_req[p] = 1'b0; m_we[p] = 1'b0; m_addr[p] = '0; m_wdata[p] = '0; exp_rdata[p] = '0;
    end
    drive_inputs(1'b0, 1'b0, '0);
    #1;
    chk("rst_enables", {bus.wr_enable, bus.rd_enable, bus.arb_busy}, 0);
    chk("rst_done_err", {bus.p0_done, bus.p1_done, bus.p0_err, bus.p1_err}, 0);
    chk("rst_addrs", {bus.wr_addr, bus.rd_addr}, 0);
    chk("rst_data", {bus.wr_data, bus.p0_rdata, bus.p1_rdata}, 0);
    chk("rst_owner", bus.arb_owner, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((inflight || m_req[0] || m_req[1]) && k < budget) begin
      step();
      k++;
    end
    chk("idle_after_drain", bus.arb_busy, 0);
  endtask

  initial begin
    auto_req = 1'b0;
    for (int p = 0; p < 2; p++) begin
      done_cnt[p] = 0; err_cnt[p] = 0;
    end
    do_reset();

    // Single read: busy after 2 cycles for 5 cycles, then rd_ready with 0xBEEF.
    f_en = 1'b1; f_kind = 0; f_a = 2; f_b = 5; f_data = 16'hBEEF;
    set_req(0, 1'b0, 25'h0001234, '0);
    drain(100);
    chk("d1_p0_rdata", bus.p0_rdata, 16'hBEEF);
    chk("d1_p0_done_cnt", done_cnt[0], 1);
    chk("d1_p1_done_cnt", done_cnt[1], 0);

    // Simultaneous writes after reset: CPU first, then DBG.
    do_reset();
    done_cnt[0] = 0; done_cnt[1] = 0;
    set_req(0, 1'b1, 25'h10, 16'h1111);
    set_req(1, 1'b1, 25'h20, 16'h2222);
    drain(100);
    chk("d2_p0_done_cnt", done_cnt[0], 1);
    chk("d2_p1_done_cnt", done_cnt[1], 1);

    // DBG read that the controller never answers.
    f_en = 1'b1; f_kind = 2; f_a = 0; f_b = 1; f_data = '0;
    set_req(1, 1'b0, 25'h3333, '0);
    drain(100);
    chk("d3_p1_err_cnt", err_cnt[1], 1);
    chk("d3_p1_rdata_kept", bus.p1_rdata, 0);
    f_en = 1'b1; f_kind = 0; f_a = 1; f_b = 2; f_data = 16'h5A5A;
    set_req(1, 1'b0, 25'h44, '0);
    drain(100);
    chk("d3_p1_done_cnt", done_cnt[1], 3);
    chk("d3_p1_err_cnt2", err_cnt[1], 1);
    chk("d3_p1_rdata_new", bus.p1_rdata, 16'h5A5A);

    // Controller busy while the request rises.
    busy_until = cyc + 8;
    set_req(0, 1'b1, 25'h55, 16'hA5A5);
    drain(100);
    chk("d4_p0_done_cnt", done_cnt[0], 2);

    // Reset while waiting on a read.
    f_en = 1'b1; f_kind = 0; f_a = 0; f_b = 8; f_data = 16'h1357;
    set_req(0, 1'b0, 25'h66, '0);
    repeat (4) step();
    chk("d5_in_flight", bus.arb_busy, 1);
    dc = done_cnt[0];
    do_reset();
    repeat (6) step();
    chk("d5_no_done", done_cnt[0], dc);
    set_req(0, 1'b0, 25'h77, '0);
    drain(100);
    chk("d5_fresh_done", done_cnt[0], dc + 1);

    // Random traffic from both ports.
    auto_req = 1'b1;
    repeat (3000) step();
    auto_req = 1'b0;
    drain(300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
